// File: rtl/cache_refill_mem_if.sv
// Request/response channel between the cache and its backing-memory responder.
// The cache is the master; the responder is the slave.
interface cache_refill_mem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err, busy
  );
endinterface

// File: rtl/cache_refill_mem.sv
// Backing-memory responder for the direct-mapped cache: single outstanding
// word access with a fixed, programmable latency between accept and response.
module cache_refill_mem #(
  parameter int ADDRESS_WIDTH = 10,
  parameter int DATA_WIDTH    = 32,
  parameter int LATENCY       = 4
) (
  input  logic               clk,
  input  logic               rst,
  cache_refill_mem_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam int          DEPTH    = 1 << ADDRESS_WIDTH;
  localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

  state_t                   r_state;
  state_t                   w_next_state;
  logic [3:0]               r_cnt;
  logic                     r_we;
  logic [31:0]              r_addr;
  logic [DATA_WIDTH-1:0]    r_wdata;
  logic [3:0]               r_be;
  logic [DATA_WIDTH-1:0]    r_rdata;
  logic                     r_err;
  logic [DATA_WIDTH-1:0]    r_mem [0:DEPTH-1];

  logic                     w_access;
  logic                     w_err;
  logic [ADDRESS_WIDTH-1:0] w_index;
  logic [DATA_WIDTH-1:0]    w_old;
  logic [DATA_WIDTH-1:0]    w_merged;

  assign w_access = (r_state == S_WAIT) && (r_cnt == 4'd0);
  assign w_err    = (r_addr[1:0] != 2'b00) || (r_addr[31:ADDRESS_WIDTH+2] != '0);
  assign w_index  = r_addr[ADDRESS_WIDTH+1:2];
  assign w_old    = r_mem[w_index];

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_merged = w_old;
    for (int i = 0; i < 4; i++) begin
      if (r_be[i]) w_merged[8*i +: 8] = r_wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state   = r_state;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.busy       = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) w_next_state = S_WAIT;
      end
      S_WAIT: begin
        bus.busy = 1'b1;
        if (r_cnt == 4'd0) w_next_state = S_RESP;
      end
      S_RESP: begin
        bus.busy       = 1'b1;
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_we    <= bus.req_we;
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
            r_be    <= bus.req_be;
            r_cnt   <= CNT_LOAD;
          end
        end
        S_WAIT: begin
          if (w_access) begin
            r_err   <= w_err;
            r_rdata <= w_err ? '0 : (r_we ? w_merged : w_old);
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the RAM array has no reset; only control state is cleared, contents survive rst.
  always_ff @(posedge clk) begin
    if (w_access && !w_err && r_we && !rst) r_mem[w_index] <= w_merged;
  end

  assign bus.resp_rdata = r_rdata;
  assign bus.resp_err   = r_err;

endmodule

// File: tb/tb_cache_refill_mem.sv
// Randomized self-checking bench: two responders (LATENCY 4 and 1) share one
// stimulus driver and are compared against a word-array reference model.
module tb_cache_refill_mem;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_refill_mem_if if4 ();
  cache_refill_mem_if if1 ();

  bit          sel;
  logic        t_req_valid = 1'b0;
  logic        t_req_we    = 1'b0;
  logic [31:0] t_req_addr  = '0;
  logic [31:0] t_req_wdata = '0;
  logic [3:0]  t_req_be    = '0;
  logic        t_resp_ready = 1'b0;

  assign if4.req_valid  = t_req_valid & ~sel;
  assign if1.req_valid  = t_req_valid &  sel;
  assign if4.resp_ready = t_resp_ready & ~sel;
  assign if1.resp_ready = t_resp_ready &  sel;
  assign if4.req_we = t_req_we;       assign if1.req_we = t_req_we;
  assign if4.req_addr = t_req_addr;   assign if1.req_addr = t_req_addr;
  assign if4.req_wdata = t_req_wdata; assign if1.req_wdata = t_req_wdata;
  assign if4.req_be = t_req_be;       assign if1.req_be = t_req_be;

  cache_refill_mem #(.ADDRESS_WIDTH(10), .DATA_WIDTH(32), .LATENCY(4)) u_dut4 (
    .clk(clk), .rst(rst), .bus(if4.slave));
  cache_refill_mem #(.ADDRESS_WIDTH(10), .DATA_WIDTH(32), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(if1.slave));

  logic        o_req_ready, o_resp_valid, o_resp_err, o_busy;
  logic [31:0] o_resp_rdata;
  assign o_req_ready  = sel ? if1.req_ready  : if4.req_ready;
  assign o_resp_valid = sel ? if1.resp_valid : if4.resp_valid;
  assign o_resp_err   = sel ? if1.resp_err   : if4.resp_err;
  assign o_busy       = sel ? if1.busy       : if4.busy;
  assign o_resp_rdata = sel ? if1.resp_rdata : if4.resp_rdata;

  int n_checks = 0;
  int n_errors = 0;

  // Reference memory contents, one word array per responder.
  bit [31:0] mem_m [2][1024];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model(input bit s, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, output logic [31:0] rd, output bit err);
    bit [31:0] word;
    int idx;
    err = (addr % 4 != 0) || (addr >= 32'd4096);
    rd  = '0;
    if (!err) begin
      idx  = int'(addr / 4);
      word = mem_m[s][idx];
      if (we) begin
        for (int b = 0; b < 4; b++) if (be[b]) word[8*b +: 8] = wdata[8*b +: 8];
        mem_m[s][idx] = word;
      end
      rd = word;
    end
  endtask

  task automatic txn(input bit s, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, input int hold, output logic [31:0] rd);
    logic [31:0] exp_rd;
    bit          exp_err;
    int          lat;
    int          g;
    model(s, we, addr, wdata, be, exp_rd, exp_err);
    @(negedge clk);
    sel = s;
    t_req_we = we; t_req_addr = addr; t_req_wdata = wdata; t_req_be = be;
    t_req_valid = 1'b1; t_resp_ready = 1'b0;
    g = 0;
    while (!o_req_ready && g < 50) begin @(negedge clk); g++; end
    rd = '0;
    if (!o_req_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      t_req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    t_req_valid = 1'b0;
    lat = 0;
    while (!o_resp_valid && lat < 50) begin @(negedge clk); lat++; end
    check("latency", lat, s ? 32'd1 : 32'd4);
    check("rdata", o_resp_rdata, exp_rd);
    check("err", {31'd0, o_resp_err}, {31'd0, exp_err});
    check("busy_resp", {31'd0, o_busy}, 32'd1);
    check("ready_resp", {31'd0, o_req_ready}, 32'd0);
    rd = o_resp_rdata;
    for (int i = 0; i < hold; i++) begin
      if (i == 0) begin
        // A competing request while the response is stalled must not be taken.
        t_req_we = 1'b1; t_req_addr = 32'h14; t_req_wdata = 32'h5A5A_5A5A; t_req_be = 4'hF;
        t_req_valid = 1'b1;
      end
      @(negedge clk);
      check("hold_valid", {31'd0, o_resp_valid}, 32'd1);
      check("hold_rdata", o_resp_rdata, exp_rd);
      check("hold_err", {31'd0, o_resp_err}, {31'd0, exp_err});
      check("hold_ready", {31'd0, o_req_ready}, 32'd0);
    end
    t_resp_ready = 1'b1;
    @(negedge clk);
    t_resp_ready = 1'b0;
    t_req_valid  = 1'b0;
    check("idle_ready", {31'd0, o_req_ready}, 32'd1);
    check("idle_valid", {31'd0, o_resp_valid}, 32'd0);
    check("idle_busy", {31'd0, o_busy}, 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] exp_w;
    logic [31:0] exp_r;
    bit          e;
    logic [31:0] wd;

    sel = 1'b0;
    #2;
    check("rst_req_ready", {31'd0, o_req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, o_resp_valid}, 32'd0);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    check("rst_rdata", o_resp_rdata, 32'd0);
    check("rst_err", {31'd0, o_resp_err}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Give a pool of 32 words known contents in both responders.
    for (int s = 0; s < 2; s++)
      for (int w = 0; w < 32; w++) txn(s[0], 1'b1, 32'(w * 4), $urandom, 4'hF, 0, rd);

    txn(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, rd);
    check("wr_deadbeef", rd, 32'hDEAD_BEEF);
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd);
    check("rd_deadbeef", rd, 32'hDEAD_BEEF);

    txn(0, 1'b1, 32'h20, 32'h1122_3344, 4'hF, 0, rd);
    txn(0, 1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, 0, rd);
    check("partial_wr", rd, 32'h11BB_33DD);
    txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, rd);
    check("partial_rd", rd, 32'h11BB_33DD);

    txn(0, 1'b0, 32'h12, 32'h0, 4'h0, 0, rd);
    check("misaligned_rdata", rd, 32'h0);
    txn(0, 1'b1, 32'h1000, 32'hFFFF_FFFF, 4'hF, 0, rd);
    txn(0, 1'b0, 32'h0, 32'h0, 4'h0, 0, rd);

    txn(0, 1'b1, 32'h24, 32'h0, 4'h0, 0, rd);
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 6, rd);
    txn(0, 1'b0, 32'h14, 32'h0, 4'h0, 0, rd);

    // Abandon a write two edges into its wait.
    @(negedge clk);
    sel = 1'b0;
    t_req_we = 1'b1; t_req_addr = 32'h40; t_req_wdata = 32'hCAFE_F00D; t_req_be = 4'hF;
    t_req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    t_req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("wait_rst_ready", {31'd0, o_req_ready}, 32'd1);
    check("wait_rst_valid", {31'd0, o_resp_valid}, 32'd0);
    check("wait_rst_busy", {31'd0, o_busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    txn(0, 1'b0, 32'h40, 32'h0, 4'h0, 0, rd);

    // LATENCY=1 back-to-back with req_valid held high throughout.
    @(negedge clk);
    sel = 1'b1;
    wd = $urandom;
    model(1, 1'b1, 32'h8, wd, 4'hF, exp_w, e);
    exp_r = '0;
    t_req_we = 1'b1; t_req_addr = 32'h8; t_req_wdata = wd; t_req_be = 4'hF;
    t_req_valid = 1'b1; t_resp_ready = 1'b1;
    for (int i = 0; i <= 6; i++) begin
      check("b2b_ready", {31'd0, o_req_ready}, (i % 3 == 0) ? 32'd1 : 32'd0);
      check("b2b_valid", {31'd0, o_resp_valid}, (i % 3 == 2) ? 32'd1 : 32'd0);
      if (i == 2) begin
        check("b2b_wr_rdata", o_resp_rdata, exp_w);
        t_req_we = 1'b0; t_req_wdata = '0; t_req_be = '0;
        model(1, 1'b0, 32'h8, 32'h0, 4'h0, exp_r, e);
      end
      if (i == 5) check("b2b_rd_rdata", o_resp_rdata, exp_r);
      if (i < 6) @(negedge clk);
    end
    t_req_valid = 1'b0; t_resp_ready = 1'b0;

    for (int n = 0; n < 60; n++) begin
      int          kind;
      logic [31:0] a;
      bit          s;
      kind = $urandom_range(0, 9);
      s    = 1'($urandom_range(0, 1));
      if (kind < 8)       a = 32'($urandom_range(0, 31) * 4);
      else if (kind == 8) a = 32'($urandom_range(0, 31) * 4 + $urandom_range(1, 3));
      else                a = ($urandom & 32'hFFFF_FFFC) | 32'h1000;
      txn(s, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
          $urandom_range(0, 2), rd);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
